// File: rtl/seg_capture.sv
// seg_capture: captures a two-digit 7-segment display (tens/ones), filters
// out transient patterns, decodes to BCD and tracks a count-down value.
//
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   seg_led_1/2  [8:0]  ones / tens segment pattern ({2'b00, gfedcba})
//   digit_ge/shi [3:0]  last accepted ones / tens digit (BCD)
//   valid               a valid value has been accepted since reset
//   step_pulse          1-cycle pulse on a decrement by exactly one
//   reload_pulse        1-cycle pulse when the value rises or leaves EXPIRED
//   zero_flag           high while in EXPIRED
//   err_invalid         1-cycle pulse on an accepted pattern that fails decode
//   err_step            1-cycle pulse on a decrement by more than one
//   step_period         cycles between the last two legal steps
//   err_count    [7:0]  saturating error count
//
// Build option: define SEG_CAPTURE_ERR_CNT_EN to build the error counter;
// otherwise err_count is tied to zero.
//
// state   | meaning
// --------+---------------------------------------------------
// S_WAIT  | nothing valid accepted since reset
// S_RUN   | tracking a nonzero value, period counter running
// S_EXP   | value reached zero, waiting for a reload
module seg_capture #(
  parameter int unsigned STABLE_CYC = 4,
  parameter int unsigned PERIOD_W   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [8:0]          seg_led_1,
  input  logic [8:0]          seg_led_2,
  output logic [3:0]          digit_ge,
  output logic [3:0]          digit_shi,
  output logic                valid,
  output logic                step_pulse,
  output logic                reload_pulse,
  output logic                zero_flag,
  output logic                err_invalid,
  output logic                err_step,
  output logic [PERIOD_W-1:0] step_period,
  output logic [7:0]          err_count
);

  localparam logic [7:0] STABLE_N = 8'(STABLE_CYC);

  typedef enum logic [1:0] {S_WAIT, S_RUN, S_EXP} state_t;

  // {ok, bcd}; the full 9 bits are matched so bits[8:7] must be 00
  function automatic logic [4:0] seg_dec(input logic [8:0] s);
    case (s)
      9'h03F:  seg_dec = 5'h10;
      9'h006:  seg_dec = 5'h11;
      9'h05B:  seg_dec = 5'h12;
      9'h04F:  seg_dec = 5'h13;
      9'h066:  seg_dec = 5'h14;
      9'h06D:  seg_dec = 5'h15;
      9'h07D:  seg_dec = 5'h16;
      9'h007:  seg_dec = 5'h17;
      9'h07F:  seg_dec = 5'h18;
      9'h06F:  seg_dec = 5'h19;
      default: seg_dec = 5'h00;
    endcase
  endfunction

  logic [17:0]         sync1_q, sync2_q;
  logic [17:0]         cand_q, cand_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [17:0]         acc_q, acc_d;
  logic                acc_vld_q, acc_vld_d;
  state_t              state_q, state_d;
  logic [3:0]          ge_q, ge_d, shi_q, shi_d;
  logic                valid_q, valid_d;
  logic                step_q, step_d, reload_q, reload_d;
  logic                einv_q, einv_d, estep_q, estep_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] pcnt_q, pcnt_d, pcnt_inc;

  logic                accept;
  logic [4:0]          dec_ge, dec_shi;
  logic                dec_ok;
  logic [6:0]          v_new, v_prev;

  // Stability filter: cnt_q counts consecutive cycles cand_q has matched
  // the synchronized inputs, saturating at STABLE_N.
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = 8'd1;
    end else if (cnt_q != STABLE_N) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  assign accept  = (cnt_q == STABLE_N) && (!acc_vld_q || (cand_q != acc_q));
  assign dec_ge  = seg_dec(cand_q[8:0]);
  assign dec_shi = seg_dec(cand_q[17:9]);
  assign dec_ok  = dec_ge[4] & dec_shi[4];
  assign v_new   = 7'(dec_shi[3:0]) * 7'd10 + 7'(dec_ge[3:0]);
  assign v_prev  = 7'(shi_q) * 7'd10 + 7'(ge_q);
  assign pcnt_inc = (&pcnt_q) ? pcnt_q : pcnt_q + PERIOD_W'(1);

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    acc_vld_d = acc_vld_q;
    ge_d      = ge_q;
    shi_d     = shi_q;
    valid_d   = valid_q;
    step_d    = 1'b0;
    reload_d  = 1'b0;
    einv_d    = 1'b0;
    estep_d   = 1'b0;
    period_d  = period_q;
    pcnt_d    = (state_q == S_RUN) ? pcnt_inc : pcnt_q;

    if (accept) begin
      acc_d     = cand_q;
      acc_vld_d = 1'b1;
      if (!dec_ok) begin
        einv_d = 1'b1;
      end else begin
        case (state_q)
          S_WAIT: begin
            ge_d    = dec_ge[3:0];
            shi_d   = dec_shi[3:0];
            valid_d = 1'b1;
            pcnt_d  = '0;
            state_d = (v_new == 7'd0) ? S_EXP : S_RUN;
          end
          S_RUN: begin
            // v_prev is never zero here: zero always moves to S_EXP
            if (v_new == v_prev - 7'd1) begin
              ge_d     = dec_ge[3:0];
              shi_d    = dec_shi[3:0];
              step_d   = 1'b1;
              period_d = pcnt_inc;  // include the current cycle
              pcnt_d   = '0;
              if (v_new == 7'd0) state_d = S_EXP;
            end else if (v_new > v_prev) begin
              ge_d     = dec_ge[3:0];
              shi_d    = dec_shi[3:0];
              reload_d = 1'b1;
              pcnt_d   = '0;
            end else if (v_new < v_prev) begin
              ge_d    = dec_ge[3:0];
              shi_d   = dec_shi[3:0];
              estep_d = 1'b1;
              pcnt_d  = '0;
              if (v_new == 7'd0) state_d = S_EXP;
            end
          end
          S_EXP: begin
            if (v_new != 7'd0) begin
              ge_d     = dec_ge[3:0];
              shi_d    = dec_shi[3:0];
              reload_d = 1'b1;
              pcnt_d   = '0;
              state_d  = S_RUN;
            end
          end
          default: state_d = S_WAIT;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      cand_q    <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      acc_vld_q <= 1'b0;
      state_q   <= S_WAIT;
      ge_q      <= '0;
      shi_q     <= '0;
      valid_q   <= 1'b0;
      step_q    <= 1'b0;
      reload_q  <= 1'b0;
      einv_q    <= 1'b0;
      estep_q   <= 1'b0;
      period_q  <= '0;
      pcnt_q    <= '0;
    end else begin
      sync1_q   <= {seg_led_2, seg_led_1};
      sync2_q   <= sync1_q;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      acc_vld_q <= acc_vld_d;
      state_q   <= state_d;
      ge_q      <= ge_d;
      shi_q     <= shi_d;
      valid_q   <= valid_d;
      step_q    <= step_d;
      reload_q  <= reload_d;
      einv_q    <= einv_d;
      estep_q   <= estep_d;
      period_q  <= period_d;
      pcnt_q    <= pcnt_d;
    end
  end

`ifdef SEG_CAPTURE_ERR_CNT_EN
  logic [7:0] errc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      errc_q <= '0;
    end else if ((einv_d || estep_d) && (errc_q != 8'hFF)) begin
      errc_q <= errc_q + 8'd1;
    end
  end

  assign err_count = errc_q;
`else
  assign err_count = '0;
`endif

  assign digit_ge     = ge_q;
  assign digit_shi    = shi_q;
  assign valid        = valid_q;
  assign step_pulse   = step_q;
  assign reload_pulse = reload_q;
  assign zero_flag    = (state_q == S_EXP);
  assign err_invalid  = einv_q;
  assign err_step     = estep_q;
  assign step_period  = period_q;

endmodule
